// File: rtl/iq_corr_pkg.sv
// iq_corr_pkg
// Shared constants and helper functions for the IQ correction pipeline.
// - ident_coef  : fixed-point 1.0 for a given number of fractional bits
// - round_const : value added before the final shift (0 when truncating)
// - sat_max/min : signed clamp bounds for a given output width
// All helpers return longint so callers can size-cast into their own widths.
package iq_corr_pkg;

  function automatic longint ident_coef(input int gain_frac);
    return longint'(1) <<< gain_frac;
  endfunction

  function automatic longint round_const(input int gain_frac, input int round_en);
    if (round_en != 0 && gain_frac > 0) begin
      return longint'(1) <<< (gain_frac - 1);
    end
    return longint'(0);
  endfunction

  function automatic longint sat_max(input int out_w);
    return (longint'(1) <<< (out_w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int out_w);
    return -(longint'(1) <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/iq_corr_round_sat.sv
// iq_corr_round_sat
// Final pipeline stage for one channel: arithmetic shift of the (already
// rounding-biased) matrix sum, clamp to the OUT_W signed range, register.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   valid_i     : the sum on sum_i belongs to a real sample
//   sum_i       : wide signed matrix sum, rounding constant included
//   val_o       : registered OUT_W result (holds last value on bubbles)
//   clamp_o     : registered clamp flag, forced 0 on bubbles
module iq_corr_round_sat
  import iq_corr_pkg::*;
#(
  parameter int SUM_W     = 40,
  parameter int OUT_W     = 16,
  parameter int GAIN_FRAC = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_i,
  input  logic signed [SUM_W-1:0] sum_i,
  output logic signed [OUT_W-1:0] val_o,
  output logic                    clamp_o
);

  localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'(sat_max(OUT_W));
  localparam logic signed [SUM_W-1:0] MIN_V = SUM_W'(sat_min(OUT_W));

  logic signed [SUM_W-1:0] shifted;
  logic signed [OUT_W-1:0] val_d, val_q;
  logic                    clamp_d, clamp_q;

  // Arithmetic shift floors; the bias added upstream turns it into round-half-up.
  assign shifted = sum_i >>> GAIN_FRAC;

  always_comb begin
    val_d   = shifted[OUT_W-1:0];
    clamp_d = 1'b0;
    if (shifted > MAX_V) begin
      val_d   = MAX_V[OUT_W-1:0];
      clamp_d = 1'b1;
    end else if (shifted < MIN_V) begin
      val_d   = MIN_V[OUT_W-1:0];
      clamp_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q   <= '0;
      clamp_q <= 1'b0;
    end else begin
      if (valid_i) begin
        val_q <= val_d;
      end
      clamp_q <= valid_i & clamp_d;
    end
  end

  assign val_o   = val_q;
  assign clamp_o = clamp_q;

endmodule

// File: rtl/iq_correction_pipe.sv
// iq_correction_pipe
// Streaming IQ corrector: DC offset removal followed by a 2x2 gain/phase
// matrix with rounding and saturation. Four register stages, one sample
// per clock, no backpressure.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   in_valid, in_real, in_imag  : input sample strobe and signed I/Q
//   cfg_b1, cfg_b2              : offsets added to I and Q
//   cfg_a11..cfg_a22            : signed matrix coefficients, GAIN_FRAC fraction bits
//   cfg_commit                  : capture all cfg_* into the shadow set
//   cfg_applied                 : pulse in the cycle the shadow set is loaded to active
//   out_valid, out_real/imag    : corrected sample and its strobe
//   out_sat                     : either channel clamped on this sample
//   sat_clear, sat_count        : saturated-sample counter (sticks at all-ones)
// Handshake: in_valid/out_valid are plain strobes; a sample is accepted on
// every rising edge where in_valid is high and leaves four edges later.
module iq_correction_pipe
  import iq_corr_pkg::*;
#(
  parameter int IN_W      = 14,
  parameter int OUT_W     = 16,
  parameter int GAIN_W    = 24,
  parameter int GAIN_FRAC = 12,
  parameter int ROUND     = 1,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [IN_W-1:0]   in_real,
  input  logic signed [IN_W-1:0]   in_imag,
  input  logic signed [IN_W-1:0]   cfg_b1,
  input  logic signed [IN_W-1:0]   cfg_b2,
  input  logic signed [GAIN_W-1:0] cfg_a11,
  input  logic signed [GAIN_W-1:0] cfg_a12,
  input  logic signed [GAIN_W-1:0] cfg_a21,
  input  logic signed [GAIN_W-1:0] cfg_a22,
  input  logic                     cfg_commit,
  output logic                     cfg_applied,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_real,
  output logic signed [OUT_W-1:0]  out_imag,
  output logic                     out_sat,
  input  logic                     sat_clear,
  output logic [CNT_W-1:0]         sat_count
);

  localparam int SW    = IN_W + 1;
  localparam int PW    = IN_W + 1 + GAIN_W;
  localparam int SUM_W = IN_W + GAIN_W + 2;

  localparam logic signed [GAIN_W-1:0] A_ONE = GAIN_W'(ident_coef(GAIN_FRAC));
  localparam logic signed [SUM_W-1:0]  RND_C = SUM_W'(round_const(GAIN_FRAC, ROUND));

  typedef struct packed {
    logic signed [IN_W-1:0]   b1;
    logic signed [IN_W-1:0]   b2;
    logic signed [GAIN_W-1:0] a11;
    logic signed [GAIN_W-1:0] a12;
    logic signed [GAIN_W-1:0] a21;
    logic signed [GAIN_W-1:0] a22;
  } coef_t;

  localparam coef_t COEF_ID = '{b1: '0, b2: '0, a11: A_ONE, a12: '0, a21: '0, a22: A_ONE};

  coef_t cfg_in;
  coef_t shadow_q, active_q;
  logic  commit_q;

  assign cfg_in = '{b1: cfg_b1, b2: cfg_b2, a11: cfg_a11, a12: cfg_a12,
                    a21: cfg_a21, a22: cfg_a22};

  // Shadow captures on the commit edge; active follows one edge later, so a
  // sample accepted on that later edge still sees the old active set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= COEF_ID;
      active_q <= COEF_ID;
      commit_q <= 1'b0;
    end else begin
      if (cfg_commit) begin
        shadow_q <= cfg_in;
      end
      if (commit_q) begin
        active_q <= shadow_q;
      end
      commit_q <= cfg_commit;
    end
  end

  assign cfg_applied = commit_q;

  // S1: offset add; the gains are copied here so the sample carries them.
  logic                     v1_q;
  logic signed [SW-1:0]     s1_r_q, s1_i_q;
  logic signed [GAIN_W-1:0] c1_a11_q, c1_a12_q, c1_a21_q, c1_a22_q;
  // S2: products
  logic                     v2_q;
  logic signed [PW-1:0]     p11_q, p12_q, p21_q, p22_q;
  // S3: matrix sums with rounding bias
  logic                     v3_q;
  logic signed [SUM_W-1:0]  sum_r_q, sum_i_q;
  // S4 valid (data lives in the round/sat instances)
  logic                     v4_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      s1_r_q   <= '0;
      s1_i_q   <= '0;
      c1_a11_q <= '0;
      c1_a12_q <= '0;
      c1_a21_q <= '0;
      c1_a22_q <= '0;
      v2_q     <= 1'b0;
      p11_q    <= '0;
      p12_q    <= '0;
      p21_q    <= '0;
      p22_q    <= '0;
      v3_q     <= 1'b0;
      sum_r_q  <= '0;
      sum_i_q  <= '0;
      v4_q     <= 1'b0;
    end else begin
      v1_q     <= in_valid;
      s1_r_q   <= SW'(in_real) + SW'(active_q.b1);
      s1_i_q   <= SW'(in_imag) + SW'(active_q.b2);
      c1_a11_q <= active_q.a11;
      c1_a12_q <= active_q.a12;
      c1_a21_q <= active_q.a21;
      c1_a22_q <= active_q.a22;

      v2_q  <= v1_q;
      p11_q <= PW'(c1_a11_q) * PW'(s1_r_q);
      p12_q <= PW'(c1_a12_q) * PW'(s1_i_q);
      p21_q <= PW'(c1_a21_q) * PW'(s1_r_q);
      p22_q <= PW'(c1_a22_q) * PW'(s1_i_q);

      v3_q    <= v2_q;
      sum_r_q <= SUM_W'(p11_q) + SUM_W'(p12_q) + RND_C;
      sum_i_q <= SUM_W'(p21_q) + SUM_W'(p22_q) + RND_C;

      v4_q <= v3_q;
    end
  end

  logic clamp_r, clamp_i;

  iq_corr_round_sat #(
    .SUM_W    (SUM_W),
    .OUT_W    (OUT_W),
    .GAIN_FRAC(GAIN_FRAC)
  ) u_rs_real (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid_i(v3_q),
    .sum_i  (sum_r_q),
    .val_o  (out_real),
    .clamp_o(clamp_r)
  );

  iq_corr_round_sat #(
    .SUM_W    (SUM_W),
    .OUT_W    (OUT_W),
    .GAIN_FRAC(GAIN_FRAC)
  ) u_rs_imag (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid_i(v3_q),
    .sum_i  (sum_i_q),
    .val_o  (out_imag),
    .clamp_o(clamp_i)
  );

  assign out_valid = v4_q;
  assign out_sat   = clamp_r | clamp_i;

  // Saturation counter, fed by the registered output flags. A clear that
  // coincides with a saturated output restarts the count at one.
  logic             sat_evt;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign sat_evt = v4_q & out_sat;

  always_comb begin
    cnt_d = cnt_q;
    if (sat_clear) begin
      cnt_d = sat_evt ? CNT_W'(1) : '0;
    end else if (sat_evt && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_count = cnt_q;

endmodule

// File: tb/tb_iq_correction_pipe.sv
module tb_iq_correction_pipe;

  localparam int IN_W   = 14;
  localparam int OUT_W  = 16;
  localparam int GAIN_W = 24;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                     in_valid = 1'b0;
  logic signed [IN_W-1:0]   in_real = '0, in_imag = '0;
  logic signed [IN_W-1:0]   cfg_b1 = '0, cfg_b2 = '0;
  logic signed [GAIN_W-1:0] cfg_a11 = '0, cfg_a12 = '0, cfg_a21 = '0, cfg_a22 = '0;
  logic                     cfg_commit = 1'b0;
  logic                     sat_clear = 1'b0;

  // rounding instance (default widths)
  logic                    r_applied, r_valid, r_sat;
  logic signed [OUT_W-1:0] r_real, r_imag;
  logic [15:0]             r_cnt;
  // truncating instance with a small counter
  logic                    t_applied, t_valid, t_sat;
  logic signed [OUT_W-1:0] t_real, t_imag;
  logic [2:0]              t_cnt;

  iq_correction_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_real(in_real), .in_imag(in_imag),
    .cfg_b1(cfg_b1), .cfg_b2(cfg_b2), .cfg_a11(cfg_a11), .cfg_a12(cfg_a12),
    .cfg_a21(cfg_a21), .cfg_a22(cfg_a22), .cfg_commit(cfg_commit), .cfg_applied(r_applied),
    .out_valid(r_valid), .out_real(r_real), .out_imag(r_imag), .out_sat(r_sat),
    .sat_clear(sat_clear), .sat_count(r_cnt)
  );

  iq_correction_pipe #(.ROUND(0), .CNT_W(3)) dut_t (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_real(in_real), .in_imag(in_imag),
    .cfg_b1(cfg_b1), .cfg_b2(cfg_b2), .cfg_a11(cfg_a11), .cfg_a12(cfg_a12),
    .cfg_a21(cfg_a21), .cfg_a22(cfg_a22), .cfg_commit(cfg_commit), .cfg_applied(t_applied),
    .out_valid(t_valid), .out_real(t_real), .out_imag(t_imag), .out_sat(t_sat),
    .sat_clear(sat_clear), .sat_count(t_cnt)
  );

  // vector record: inputs, config, expected (round) and expected (truncate)
  typedef struct {
    int in_r; int in_i; int b1; int b2; int a11; int a12; int a21; int a22;
    int er; int ei; int es; int tr; int ti;
  } vec_t;

  vec_t        vecs[12];
  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          ecnt = 0;
  int          tcnt = 0;
  int          n_app = 0;
  int          app_at = -1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_cfg(input vec_t v);
    cfg_b1  = IN_W'(v.b1);
    cfg_b2  = IN_W'(v.b2);
    cfg_a11 = GAIN_W'(v.a11);
    cfg_a12 = GAIN_W'(v.a12);
    cfg_a21 = GAIN_W'(v.a21);
    cfg_a22 = GAIN_W'(v.a22);
  endtask

  task automatic commit_vec(input vec_t v, input int idx);
    apply_cfg(v);
    cfg_commit = 1'b1;
    step();
    check($sformatf("v%0d_applied_hi", idx), r_applied, 1);
    cfg_commit = 1'b0;
    step();
    check($sformatf("v%0d_applied_lo", idx), r_applied, 0);
  endtask

  // drive one sample for one cycle, return edges until out_valid (bounded)
  task automatic send_one(input int re, input int im, output int lat);
    in_real  = IN_W'(re);
    in_imag  = IN_W'(im);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!r_valid && lat < 10) begin
      step();
      lat++;
    end
  endtask

  task automatic monitor_stream(input int i);
    logic [31:0] e;
    if (r_applied) begin
      n_app++;
      app_at = i;
    end
    if (r_valid) begin
      if (exp_q.size() == 0) begin
        check("stream_extra_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("stream_real", r_real, $signed(e[31:16]));
        check("stream_imag", r_imag, $signed(e[15:0]));
      end
    end
  endtask

  initial begin
    int   lat;
    int   n_sp;
    vec_t tmp;
    logic [31:0] old_v;
    logic [31:0] new_v;

    //            in_r   in_i   b1    b2     a11    a12    a21    a22   er     ei     es tr     ti
    vecs[0]  = '{100,   -50,   0,    0,     4096,  0,     0,     4096, 100,   -50,   0, 100,   -50};
    vecs[1]  = '{100,   20,    10,   0,     2048,  4096,  0,     4096, 75,    20,    0, 75,    20};
    vecs[2]  = '{8191,  8191,  0,    0,     16384, 16384, 0,     4096, 32767, 8191,  1, 32767, 8191};
    vecs[3]  = '{-8192, -8192, 0,    0,     16384, 16384, 0,     4096, -32768,-8192, 1, -32768,-8192};
    vecs[4]  = '{3,     0,     0,    0,     2048,  0,     0,     4096, 2,     0,     0, 1,     0};
    vecs[5]  = '{-3,    0,     0,    0,     2048,  0,     0,     4096, -1,    0,     0, -2,    0};
    vecs[6]  = '{8191,  -8192, 8191, -8192, 4096,  0,     0,     4096, 16382, -16384,0, 16382, -16384};
    vecs[7]  = '{8191,  0,     0,    0,     4096,  0,     20480, 0,    8191,  32767, 1, 8191,  32767};
    vecs[8]  = '{8191,  8191,  0,    1,     4096,  12288, 0,     4096, 32767, 8192,  0, 32767, 8192};
    vecs[9]  = '{-8192, -8192, 0,    0,     4096,  12288, 0,     4096, -32768,-8192, 0, -32768,-8192};
    vecs[10] = '{-1,    -1,    0,    0,     4096,  4096,  4096,  -4096,-2,    0,     0, -2,    0};
    vecs[11] = '{8191,  8191,  1,    1,     4096,  12288, 0,     4096, 32767, 8192,  1, 32767, 8192};

    // reset state
    step();
    step();
    check("rst_valid", r_valid, 0);
    check("rst_real", r_real, 0);
    check("rst_imag", r_imag, 0);
    check("rst_sat", r_sat, 0);
    check("rst_cnt", r_cnt, 0);
    check("rst_applied", r_applied, 0);
    rst_n = 1'b1;
    step();

    // identity defaults straight out of reset
    send_one(100, -50, lat);
    check("dflt_latency", lat, 4);
    check("dflt_real", r_real, 100);
    check("dflt_imag", r_imag, -50);
    check("dflt_sat", r_sat, 0);
    step();

    // continuous stream with a commit alongside sample 3
    apply_cfg(vecs[1]);
    in_real = IN_W'(100);
    in_imag = IN_W'(20);
    old_v   = {16'd100, 16'd20};
    new_v   = {16'd75, 16'd20};
    for (int i = 0; i < 8; i++) begin
      in_valid   = 1'b1;
      cfg_commit = (i == 3);
      exp_q.push_back((i <= 4) ? old_v : new_v);
      step();
      monitor_stream(i);
    end
    in_valid   = 1'b0;
    cfg_commit = 1'b0;
    for (int i = 8; i < 16; i++) begin
      step();
      monitor_stream(i);
    end
    check("stream_left", exp_q.size(), 0);
    check("stream_applied_cnt", n_app, 1);
    check("stream_applied_at", app_at, 3);

    // back-to-back commits: the second one must win
    tmp = vecs[0];
    tmp.a11 = 12288;
    apply_cfg(tmp);
    cfg_commit = 1'b1;
    step();
    check("b2b_applied_1", r_applied, 1);
    apply_cfg(vecs[0]);
    step();
    check("b2b_applied_2", r_applied, 1);
    cfg_commit = 1'b0;
    step();
    check("b2b_applied_off", r_applied, 0);
    send_one(7, 5, lat);
    check("b2b_latency", lat, 4);
    check("b2b_real", r_real, 7);
    check("b2b_imag", r_imag, 5);
    step();

    // table-driven vectors
    for (int i = 0; i < 12; i++) begin
      commit_vec(vecs[i], i);
      send_one(vecs[i].in_r, vecs[i].in_i, lat);
      check($sformatf("v%0d_latency", i), lat, 4);
      check($sformatf("v%0d_real", i), r_real, vecs[i].er);
      check($sformatf("v%0d_imag", i), r_imag, vecs[i].ei);
      check($sformatf("v%0d_sat", i), r_sat, vecs[i].es);
      check($sformatf("v%0d_t_valid", i), t_valid, 1);
      check($sformatf("v%0d_t_real", i), t_real, vecs[i].tr);
      check($sformatf("v%0d_t_imag", i), t_imag, vecs[i].ti);
      check($sformatf("v%0d_t_sat", i), t_sat, vecs[i].es);
      if (vecs[i].es != 0) begin
        ecnt++;
        if (tcnt < 7) tcnt++;
      end
      step();
      check($sformatf("v%0d_bubble_valid", i), r_valid, 0);
      check($sformatf("v%0d_bubble_sat", i), r_sat, 0);
      check($sformatf("v%0d_cnt", i), r_cnt, ecnt);
      check($sformatf("v%0d_t_cnt", i), t_cnt, tcnt);
    end

    // saturating burst: small counter must stick at all-ones
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    repeat (8) step();
    ecnt += 6;
    tcnt = (tcnt + 6 > 7) ? 7 : tcnt + 6;
    check("burst_cnt", r_cnt, ecnt);
    check("burst_t_cnt_held", t_cnt, tcnt);

    // clear coincident with a saturated output restarts at one
    send_one(vecs[11].in_r, vecs[11].in_i, lat);
    check("clr_latency", lat, 4);
    check("clr_sat", r_sat, 1);
    sat_clear = 1'b1;
    step();
    sat_clear = 1'b0;
    check("clr_coincident_cnt", r_cnt, 1);
    check("clr_coincident_t_cnt", t_cnt, 1);
    sat_clear = 1'b1;
    step();
    sat_clear = 1'b0;
    check("clr_alone_cnt", r_cnt, 0);

    // reset asserted mid-stream
    in_valid = 1'b1;
    repeat (6) step();
    check("mid_valid_before", r_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", r_valid, 0);
    check("mid_rst_real", r_real, 0);
    check("mid_rst_imag", r_imag, 0);
    check("mid_rst_sat", r_sat, 0);
    check("mid_rst_cnt", r_cnt, 0);
    repeat (2) step();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    n_sp = 0;
    repeat (5) begin
      step();
      if (r_valid || t_valid) n_sp++;
    end
    check("mid_rst_spurious", n_sp, 0);
    send_one(100, -50, lat);
    check("post_rst_latency", lat, 4);
    check("post_rst_real", r_real, 100);
    check("post_rst_imag", r_imag, -50);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
